// File: rtl/logic_pkg.sv
// Shared opcode type and gate evaluation helpers for the bitwise logic unit.
package logic_pkg;

    localparam int unsigned GATE_MAX_W = 64;

    typedef enum logic [2:0] {
        OP_BUF  = 3'd0,
        OP_NOT  = 3'd1,
        OP_AND  = 3'd2,
        OP_NAND = 3'd3,
        OP_OR   = 3'd4,
        OP_NOR  = 3'd5,
        OP_XOR  = 3'd6,
        OP_XNOR = 3'd7
    } gate_op_e;

    // Single-bit gate primitive; BUF and NOT ignore b.
    function automatic logic gate_bit(input gate_op_e op, input logic a, input logic b);
        logic y;
        y = a;
        case (op)
            OP_BUF:  y = a;
            OP_NOT:  y = ~a;
            OP_AND:  y = a & b;
            OP_NAND: y = ~(a & b);
            OP_OR:   y = a | b;
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: y = a;
        endcase
        return y;
    endfunction

    // Vector form for callers up to GATE_MAX_W bits wide.
    function automatic logic [GATE_MAX_W-1:0] gate_eval(input gate_op_e op,
                                                        input logic [GATE_MAX_W-1:0] a,
                                                        input logic [GATE_MAX_W-1:0] b);
        logic [GATE_MAX_W-1:0] y;
        y = '0;
        for (int i = 0; i < int'(GATE_MAX_W); i++) begin
            y[i] = gate_bit(op, a[i], b[i]);
        end
        return y;
    endfunction

endpackage

// File: rtl/logic_gate_vec.sv
// Combinational WIDTH-bit bitwise gate selected by opcode.
module logic_gate_vec
    import logic_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  gate_op_e         i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);

    for (genvar g = 0; g < int'(WIDTH); g++) begin : g_bit
        assign o_y[g] = gate_bit(i_op, i_a[g], i_b[g]);
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit with accumulator chaining,
// result flags and a handoff counter.
module logic_unit_pipe
    import logic_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity,
    output logic [CNT_W-1:0] result_count
);

    logic             r_s1_valid;
    gate_op_e         r_s1_op;
    logic             r_s1_acc;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_y;
    logic             r_out_zero;
    logic             r_out_ones;
    logic             r_out_parity;

    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_count;

    logic             w_s2_advance;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_handoff;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_y;

    assign w_s2_advance = r_s1_valid && (!r_out_valid || out_ready);
    assign w_in_ready   = !r_s1_valid || w_s2_advance;
    assign w_accept     = in_valid && w_in_ready;
    assign w_handoff    = r_out_valid && out_ready;
    assign w_b_eff      = r_s1_acc ? r_acc : r_s1_b;

    logic_gate_vec #(.WIDTH(WIDTH)) u_gate (
        .i_op (r_s1_op),
        .i_a  (r_s1_a),
        .i_b  (w_b_eff),
        .o_y  (w_y)
    );

    // Stage 1: operand register; refills on the same edge its content advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= OP_BUF;
            r_s1_acc   <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_op    <= gate_op_e'(in_op);
            r_s1_acc   <= in_acc;
            r_s1_a     <= in_a;
            r_s1_b     <= in_b;
        end else if (w_s2_advance) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: result and flags, held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_y      <= '0;
            r_out_zero   <= 1'b1;
            r_out_ones   <= 1'b0;
            r_out_parity <= 1'b0;
        end else if (w_s2_advance) begin
            r_out_valid  <= 1'b1;
            r_out_y      <= w_y;
            r_out_zero   <= ~|w_y;
            r_out_ones   <= &w_y;
            r_out_parity <= ^w_y;
        end else if (w_handoff) begin
            r_out_valid  <= 1'b0;
        end
    end

    // Accumulator tracks every result; clear wins over a coincident update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (acc_clr) begin
            r_acc <= '0;
        end else if (w_s2_advance) begin
            r_acc <= w_y;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_handoff) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = r_out_valid;
    assign out_y        = r_out_y;
    assign out_zero     = r_out_zero;
    assign out_ones     = r_out_ones;
    assign out_parity   = r_out_parity;
    assign result_count = r_count;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed and randomized checks of logic_unit_pipe against an in-order result model.
module tb_logic_unit_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic       in_acc;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       acc_clr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic       out_zero;
    logic       out_ones;
    logic       out_parity;
    logic [3:0] result_count;

    logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_acc       (in_acc),
        .in_a         (in_a),
        .in_b         (in_b),
        .acc_clr      (acc_clr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_y        (out_y),
        .out_zero     (out_zero),
        .out_ones     (out_ones),
        .out_parity   (out_parity),
        .result_count (result_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] golden_q[$];
    logic [7:0] model_acc = 8'h00;
    int         model_cnt = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_y = 8'h00;

    // Gate = base function {A, AND, OR, XOR} chosen by op/2, inverted when op is odd.
    function automatic logic [7:0] model_gate(input int op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] base;
        case (op / 2)
            0:       base = a;
            1:       base = a & b;
            2:       base = a | b;
            default: base = a ^ b;
        endcase
        return (op % 2 == 1) ? ~base : base;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at posedge+1.
    task automatic cycle(input bit v, input int op, input bit acc, input logic [7:0] a,
                         input logic [7:0] b, input bit clr, input bit ordy, output bit accepted);
        logic [7:0] e;
        in_valid = v; in_op = 3'(op); in_acc = acc; in_a = a; in_b = b;
        acc_clr = clr; out_ready = ordy;
        #1;
        chk("count", 32'(result_count), 32'(model_cnt % 16));
        if (prev_stall) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_y", 32'(out_y), 32'(prev_y));
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_result", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_y", 32'(out_y), 32'(e));
                chk("out_zero", 32'(out_zero), 32'(e == 8'h00));
                chk("out_ones", 32'(out_ones), 32'(e == 8'hFF));
                chk("out_parity", 32'(out_parity), 32'(^e));
                if (golden_q.size() != 0) chk("golden_y", 32'(out_y), 32'(golden_q.pop_front()));
            end
            model_cnt++;
        end
        prev_stall = out_valid && !out_ready;
        prev_y     = out_y;
        if (clr) model_acc = 8'h00;
        accepted = in_valid && in_ready;
        if (accepted) begin
            e = model_gate(op, a, acc ? model_acc : b);
            model_acc = e;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int op, input bit acc, input logic [7:0] a, input logic [7:0] b,
                        input bit ordy, output bit first_try);
        bit ok;
        first_try = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            cycle(1'b1, op, acc, a, b, 1'b0, ordy, ok);
            if (i == 0) first_try = ok;
        end
        chk("send_accepted", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        bit ok;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            cycle(1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, ok);
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        golden_q.delete();
    endtask

    task automatic reset_dut(input bit check);
        in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
        rst = 1'b1;
        #1;
        if (check) begin
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_y", 32'(out_y), 32'd0);
            chk("rst_out_zero", 32'(out_zero), 32'd1);
            chk("rst_out_ones", 32'(out_ones), 32'd0);
            chk("rst_out_parity", 32'(out_parity), 32'd0);
            chk("rst_count", 32'(result_count), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        if (check) begin
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_no_partial", 32'(out_valid), 32'd0);
        end
        exp_q.delete();
        golden_q.delete();
        model_acc  = 8'h00;
        model_cnt  = 0;
        prev_stall = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit         ok;
        bit         ft;
        int         bp_ops[3];
        logic [7:0] sweep_exp[8];
        logic [7:0] ra;
        logic [7:0] rb;
        bit         rv;
        bit         rr;

        rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_acc = 1'b0;
        in_a = 8'h00; in_b = 8'h00; acc_clr = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        reset_dut(1'b1);

        // Opcode sweep, one result per cycle.
        sweep_exp = '{8'hA5, 8'h5A, 8'h24, 8'hDB, 8'hBD, 8'h42, 8'h99, 8'h66};
        for (int op = 0; op < 8; op++) begin
            golden_q.push_back(sweep_exp[op]);
            send(op, 1'b0, 8'hA5, 8'h3C, 1'b1, ft);
            chk("sweep_no_bubble", 32'(ft), 32'd1);
        end
        drain();
        chk("sweep_count", 32'(result_count), 32'd8);

        // Reset with both stages occupied.
        for (int i = 0; i < 3; i++) cycle(1'b1, 6, 1'b0, 8'($urandom), 8'($urandom), 1'b0, 1'b0, ok);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        reset_dut(1'b1);

        // Backpressure: consumer stalled for 5 cycles with 3 offers.
        bp_ops = '{2, 4, 6};
        golden_q.push_back(8'h24); golden_q.push_back(8'hBD); golden_q.push_back(8'h99);
        begin
            int idx = 0;
            for (int c = 0; c < 5; c++) begin
                cycle(1'b1, bp_ops[idx], 1'b0, 8'hA5, 8'h3C, 1'b0, 1'b0, ok);
                chk("bp_accept", 32'(ok), 32'(c < 2));
                if (ok) idx++;
            end
            send(bp_ops[idx], 1'b0, 8'hA5, 8'h3C, 1'b1, ft);
        end
        drain();
        chk("bp_count", 32'(result_count), 32'd3);

        // Accumulator chain.
        cycle(1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, ok);
        golden_q.push_back(8'h0F); golden_q.push_back(8'hFF); golden_q.push_back(8'h00);
        send(6, 1'b1, 8'h0F, 8'h55, 1'b1, ft);
        send(6, 1'b1, 8'hF0, 8'h55, 1'b1, ft);
        chk("acc_no_bubble", 32'(ft), 32'd1);
        send(1, 1'b0, 8'hFF, 8'h12, 1'b1, ft);
        drain();

        // Clear coincident with an advancing acc transaction.
        golden_q.push_back(8'hFF); golden_q.push_back(8'hF0); golden_q.push_back(8'h00);
        send(0, 1'b0, 8'hFF, 8'h00, 1'b1, ft);
        send(6, 1'b1, 8'h0F, 8'hAA, 1'b1, ft);
        cycle(1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, ok);
        send(4, 1'b1, 8'h00, 8'hFF, 1'b1, ft);
        drain();

        // Randomized traffic with random stalls and occasional clears.
        for (int i = 0; i < 400; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 3) != 0);
            cycle(rv, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ra, rb,
                  rr && ($urandom_range(0, 15) == 0), rr, ok);
        end
        drain();

        // Counter wrap at 4 bits.
        reset_dut(1'b0);
        for (int i = 0; i < 17; i++) send(int'($urandom_range(0, 7)), 1'b0, 8'($urandom), 8'($urandom), 1'b1, ft);
        drain();
        chk("wrap_count", 32'(result_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the team's single-bit gate primitives.
- Applies one of eight bitwise gate functions (BUF, NOT, AND, NAND, OR, NOR, XOR, XNOR) to WIDTH-bit operands, selected per transaction.
- Adds a valid/ready handshake, a two-stage pipeline with backpressure, an accumulator mode that chains results, result flags, and a completion counter.
- Sits between an operand producer and a result consumer in datapath test structures.

Parameters:
- WIDTH, 8, operand/result width in bits (≥1).
- CNT_W, 16, width of the completed-result counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand transaction valid.
- in_ready  out  1  block can accept a transaction.
- in_op  in  3  opcode: 0 BUF, 1 NOT, 2 AND, 3 NAND, 4 OR, 5 NOR, 6 XOR, 7 XNOR.
- in_acc  in  1  1 = use accumulator in place of in_b.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- acc_clr  in  1  synchronous accumulator clear.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_y  out  WIDTH  result.
- out_zero  out  1  out_y == 0.
- out_ones  out  1  out_y == all ones.
- out_parity  out  1  XOR-reduction of out_y.
- result_count  out  CNT_W  number of results handed off since reset.

Behaviour:
- Reset (async, while rst=1):
  - s1_valid=0, out_valid=0, out_y=0, out_zero=1, out_ones=0, out_parity=0.
  - acc=0, result_count=0.
  - in_ready=1 combinationally from the first cycle after reset deasserts.
- Stage 1 (operand register):
  - Captures op, acc flag, A and B on edge when in_valid && in_ready.
  - in_ready = !s1_valid || s2_advance.
- Stage 2 (result register):
  - s2_advance = s1_valid && (!out_valid || out_ready).
  - On s2_advance the result is computed from stage-1 contents and registered into out_y and the flags; out_valid=1.
  - If out_valid && out_ready && !s1_valid, out_valid clears.
- Latency: a transaction accepted at edge k presents out_valid=1 after edge k+1 when unstalled. Throughput is 1 per cycle with out_ready held at 1.
- Backpressure:
  - While out_valid && !out_ready, out_y and the flags hold stable.
  - Stage 1 holds its contents.
  - in_ready deasserts once stage 1 is full.
  - No transaction is dropped or duplicated.
- Operand B selection:
  - Effective B = acc when the stage-1 acc flag = 1, else stage-1 B.
  - BUF and NOT use A only and ignore B.
  - Gate functions are bitwise per bit over WIDTH.
- Accumulator:
  - acc <= result on every s2_advance, whether or not the acc flag is set.
  - Back-to-back acc transactions therefore chain with no bubble.
  - acc_clr=1: acc <= 0 at that edge. This takes priority over a concurrent s2_advance update; that advancing result still uses the pre-clear acc.
- Counter:
  - result_count increments on out_valid && out_ready.
  - Wraps modulo 2^CNT_W.
- Simultaneous events:
  - Accept and stage-2 advance on the same edge is legal: stage 1 refills while its old content moves on.
  - Handoff and new result on the same edge: out_valid stays 1 and out_y updates.
- Reset mid-operation: in-flight transactions are discarded, with no partial output.
- Input constraints:
  - Inputs are sampled only at handshake.
  - in_op values are all defined, so there is no illegal-op case.

Decomposition:
- Shared package logic_pkg:
  - 3-bit opcode typedef with the eight named constants above.
  - Function gate_eval(op, a, b) returning the WIDTH-bit result.
- One natural sub-module: logic_gate_vec (combinational, parametrised WIDTH, op/a/b → y). It is instantiated once at stage 2 and also reusable elsewhere.
- Pipeline control, accumulator and counter live in the top.

Test Plan:
- Reset values: assert rst mid-run with both stages full → out_valid=0, out_y=0, out_zero=1, result_count=0, in_ready=1 after release.
- Opcode sweep, WIDTH=8, A=8'hA5, B=8'h3C, ops 0..7, out_ready=1:
  - Expected out_y in order: A5, 5A, 24, DB, BD, 42, 99, 66.
  - 99 gives parity=0; one result per cycle; result_count=8.
- Backpressure: hold out_ready=0 for 5 cycles while offering 3 transactions:
  - in_ready falls after 2 are accepted; out_y is stable throughout.
  - After release, all 3 results arrive in order and result_count=3.
- Accumulator chain: acc_clr pulse, then XOR with in_acc=1, A=0F, then A=F0, back-to-back:
  - out_y = 0F, then FF; out_ones=1 on FF.
  - A following NOT with A=FF gives 00 and out_zero=1.
- acc_clr coincident with an advancing acc transaction (acc=FF, XOR, A=0F) → out_y=F0 and acc=0 afterwards. Next acc OR with A=00 → 00.
- Counter wrap with CNT_W=4: 17 handoffs → result_count=1.
